// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan
//   Multiplexed 7-segment scan driver for a row of BCD digits. A load strobe
//   captures the packed digits and decimal points into shadow registers; a
//   prescaler then walks a one-hot digit enable across the row, presenting
//   the decoded segment pattern and decimal point of the enabled digit.
//
// Parameters
//   NDIG      number of digits, 1..8
//   SCAN_DIV  clock cycles each digit stays enabled, >= 1
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   bcd_in      packed BCD digits, [3:0] is digit 0 (least significant)
//   dp_in       decimal point per digit, bit i belongs to digit i
//   load        capture strobe for bcd_in / dp_in
//   an          one-hot digit enable, active-high
//   seg         segments a..g on seg[0]..seg[6], active-high
//   dp          decimal point of the enabled digit
//   frame_done  one-cycle pulse after each complete scan of all digits
//   err         sticky non-BCD flag, re-evaluated on every load
//
// Build option
//   SEG_LZB_EN  when defined, leading zeros (digits above 0 whose nibble and
//               all higher nibbles are zero) drive seg=0 while still scanned.
//
// Scan state
//   idx         | meaning
//   ------------+-----------------------------------------------
//   0           | least significant digit enabled
//   1..NDIG-2   | intermediate digit enabled
//   NDIG-1      | most significant digit; wrap to 0 ends a frame
module bcd_seg_scan #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              load,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame_done,
  output logic              err
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] ILAST = IW'(NDIG - 1);

  // current state
  logic [PW-1:0]     pcnt_q;
  logic [IW-1:0]     idx_q;
  logic [4*NDIG-1:0] shd_bcd_q;
  logic [NDIG-1:0]   shd_dp_q;
  logic              err_q;

  // next state
  logic [PW-1:0]     pcnt_d;
  logic [IW-1:0]     idx_d;
  logic [4*NDIG-1:0] shd_bcd_d;
  logic [NDIG-1:0]   shd_dp_d;
  logic              err_d;
  logic              frame_d;

  // next outputs
  logic [NDIG-1:0]   an_d;
  logic [6:0]        seg_d;
  logic              dp_d;
  logic [NDIG-1:0]   blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;   // non-BCD shows a dash
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------
  // State register (outputs are registered here too so an/seg/dp always
  // describe the idx held after the same edge)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      shd_bcd_q  <= '0;
      shd_dp_q   <= '0;
      err_q      <= 1'b0;
      an         <= '0;
      seg        <= '0;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      shd_bcd_q  <= shd_bcd_d;
      shd_dp_q   <= shd_dp_d;
      err_q      <= err_d;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= frame_d;
    end
  end

  assign err = err_q;

  // ---------------------------------------------------------------------
  // Next-state logic: prescaler, digit index, shadow capture, error flag
  // ---------------------------------------------------------------------
  always_comb begin
    pcnt_d    = pcnt_q;
    idx_d     = idx_q;
    frame_d   = 1'b0;
    shd_bcd_d = shd_bcd_q;
    shd_dp_d  = shd_dp_q;
    err_d     = err_q;

    if (pcnt_q == PLAST) begin
      pcnt_d = '0;
      if (idx_q == ILAST) begin
        idx_d   = '0;
        frame_d = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      pcnt_d = pcnt_q + PW'(1);
    end

    // load is independent of the scan: it only replaces the shadows, so a
    // load on an advance edge is seen by the newly enabled digit
    if (load) begin
      shd_bcd_d = bcd_in;
      shd_dp_d  = dp_in;
      err_d     = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        if (bcd_in[4*i +: 4] > 4'd9) err_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output logic: decode the next shadow nibble at the next index
  // ---------------------------------------------------------------------
`ifdef SEG_LZB_EN
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    blank    = '0;
    // walk down from the most significant digit; digit 0 is never blanked
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_run = zero_run & (shd_bcd_d[4*i +: 4] == 4'd0);
      blank[i] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    logic [3:0] nib;
    logic       blk;
    an_d = '0;
    nib  = 4'd0;
    blk  = 1'b0;
    dp_d = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_d == IW'(i)) begin
        an_d[i] = 1'b1;
        nib     = shd_bcd_d[4*i +: 4];
        dp_d    = shd_dp_d[i];
        blk     = blank[i];
      end
    end
    seg_d = blk ? 7'h00 : seg_decode(nib);
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Testbench for bcd_seg_scan (NDIG=4, SCAN_DIV=4). The stimulus process
// queues hand-computed expectations tagged with the cycle count since reset
// release; the monitor pops and compares them at each falling edge, or on a
// probe event for checks made while reset is asserted between edges.
module tb_bcd_seg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;
  logic        err;

  bcd_seg_scan #(.NDIG(4), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

`ifdef SEG_LZB_EN
  localparam logic [6:0] ZB = 7'h00;
`else
  localparam logic [6:0] ZB = 7'h3F;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       err;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  event probe;

  // edges since reset release: edge 1 is the first edge after release
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc = 0;
    else      cyc = cyc + 1;
  end

  // cycles k0..k1, digit i enabled when (k/4)%4 == i, frame pulse every 16
  task automatic push_span(input int k0, input int k1,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] dpv, input logic errv);
    for (int k = k0; k <= k1; k++) begin
      exp_t e;
      int   ix;
      ix    = (k / 4) % 4;
      e.cyc = k;
      e.an  = 4'b0001 << ix;
      case (ix)
        0:       e.seg = s0;
        1:       e.seg = s1;
        2:       e.seg = s2;
        default: e.seg = s3;
      endcase
      e.dp  = dpv[ix];
      e.err = errv;
      e.fd  = (k % 16 == 0);
      q.push_back(e);
    end
  endtask

  task automatic push_reset();
    exp_t e;
    e.cyc = 0;
    e.an  = 4'b0000;
    e.seg = 7'h00;
    e.dp  = 1'b0;
    e.err = 1'b0;
    e.fd  = 1'b0;
    q.push_back(e);
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk or probe);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        total++;
        if (e.cyc < cyc) begin
          bad++;
          $display("FAIL missed cyc=%0d (now %0d)", e.cyc, cyc);
        end else if ({an, seg, dp, err, frame_done} !== {e.an, e.seg, e.dp, e.err, e.fd}) begin
          bad++;
          $display("FAIL scan cyc=%0d got an=%b seg=%h dp=%b err=%b fd=%b want an=%b seg=%h dp=%b err=%b fd=%b",
                   cyc, an, seg, dp, err, frame_done, e.an, e.seg, e.dp, e.err, e.fd);
        end
      end
    end
  end

  task automatic wait_cyc(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cyc != k && n < 1000);
    if (cyc != k) begin
      total++;
      bad++;
      $display("FAIL wait_cyc got=%0d want=%0d", cyc, k);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load   = 1'b1;
    bcd_in = v;
    dp_in  = d;
  endtask

  initial begin
    // reset held, then release at a falling edge
    push_reset();
    push_span(1, 32, 7'h3F, ZB, ZB, ZB, 4'b0000, 1'b0);
    push_span(33, 51, 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0100, 1'b0);      // 0x1234
    push_span(52, 67, 7'h07, ZB, ZB, ZB, 4'b0000, 1'b0);               // 0x0007
    push_span(68, 83, 7'h6D, 7'h40, ZB, ZB, 4'b0000, 1'b1);            // 0x00A5
    push_span(84, 101, 7'h3F, ZB, ZB, ZB, 4'b0000, 1'b0);              // 0x0000
    push_span(102, 116, 7'h3F, 7'h6F, ZB, ZB, 4'b0000, 1'b0);          // 0x0090 mid-dwell
    push_span(117, 117, 7'h3F, 7'h06, ZB, ZB, 4'b0000, 1'b0);          // held load 0x0010
    push_span(118, 118, 7'h3F, 7'h5B, ZB, ZB, 4'b0000, 1'b0);          // 0x0020
    push_span(119, 123, 7'h3F, 7'h4F, ZB, ZB, 4'b0000, 1'b0);          // 0x0030
    push_span(124, 125, 7'h06, 7'h5B, 7'h4F, 7'h40, 4'b1000, 1'b1);    // 0xB321

    #2 -> probe;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    wait_cyc(32);  do_load(16'h1234, 4'b0100);
    wait_cyc(33);  load = 1'b0;
    wait_cyc(51);  do_load(16'h0007, 4'b0000);
    wait_cyc(52);  load = 1'b0;
    wait_cyc(67);  do_load(16'h00A5, 4'b0000);
    wait_cyc(68);  load = 1'b0;
    wait_cyc(83);  do_load(16'h0000, 4'b0000);
    wait_cyc(84);  load = 1'b0;
    wait_cyc(101); do_load(16'h0090, 4'b0000);
    wait_cyc(102); load = 1'b0;
    wait_cyc(116); do_load(16'h0010, 4'b0000);
    wait_cyc(117); do_load(16'h0020, 4'b0000);
    wait_cyc(118); do_load(16'h0030, 4'b0000);
    wait_cyc(119); load = 1'b0;
    wait_cyc(123); do_load(16'hB321, 4'b1000);
    wait_cyc(124); load = 1'b0;
    wait_cyc(125);

    // asynchronous reset pulse between edges while digit 3 is enabled
    @(posedge clk);
    #2 rst = 1'b0;
    push_reset();
    push_span(1, 20, 7'h3F, ZB, ZB, ZB, 4'b0000, 1'b0);
    #1 -> probe;
    #1 rst = 1'b1;

    for (int n = 0; n < 100 && q.size() > 0; n++) @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL unchecked cyc=%0d got none want an=%b seg=%h", e.cyc, e.an, e.seg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
